// File: rtl/instr_fetch_buf_pkg.sv
// Shared types for the serial instruction fetcher: FSM states, decoded-instruction layout
// and default field widths.
package instr_pkg;

    localparam int unsigned    DEF_OP_W    = 3;
    localparam int unsigned    DEF_REG_W   = 3;
    localparam int unsigned    DEF_IMM_W   = 8;
    localparam logic [7:0]     DEF_IMM_OPS = 8'hD4;
    localparam logic [DEF_OP_W-1:0] OP_NOP = '0;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        W1   = 2'd1,
        W2   = 2'd2,
        W3   = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [DEF_OP_W-1:0]  opcode;
        logic [DEF_REG_W-1:0] src_a;
        logic [DEF_REG_W-1:0] src_b;
        logic [DEF_REG_W-1:0] dest;
        logic [DEF_IMM_W-1:0] imm;
    } instr_t;

endpackage

// File: rtl/instr_fetch_buf_if.sv
// Serial word input and decoded-instruction output handshakes of the instruction fetcher.
interface instr_fetch_buf_if #(
    parameter int unsigned OP_W  = 3,
    parameter int unsigned REG_W = 3,
    parameter int unsigned IMM_W = 8
);
    logic [OP_W+REG_W-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [OP_W-1:0]       opcode;
    logic [REG_W-1:0]      src_a;
    logic [REG_W-1:0]      src_b;
    logic [REG_W-1:0]      dest;
    logic [IMM_W-1:0]      imm;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_valid, opcode, src_a, src_b, dest, imm
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_valid, opcode, src_a, src_b, dest, imm
    );
endinterface

// File: rtl/instr_fetch_buf_fifo.sv
// DEPTH-entry FIFO with a registered head copy and count-based full/empty flags.
module instr_fifo #(
    parameter int unsigned W     = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_valid,
    output logic         o_full
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_head;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_valid   = (r_cnt != '0);
    assign o_head    = r_head;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && o_valid;

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_head <= '0;
        end else begin
            if (w_do_push)
                r_wr <= r_wr + PW'(1);
            if (w_do_pop)
                r_rd <= r_rd + PW'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            // Head mirrors r_mem[r_rd]; on a pop the next entry comes from memory
            // unless the FIFO drains, in which case a simultaneous push bypasses.
            if (w_do_pop) begin
                if (r_cnt > CW'(1))
                    r_head <= r_mem[r_rd + PW'(1)];
                else if (w_do_push)
                    r_head <= i_din;
            end else if (w_do_push && !o_valid) begin
                r_head <= i_din;
            end
        end
    end
endmodule

// File: rtl/instr_fetch_buf.sv
// Serial instruction fetcher: syncs on an all-ones word, assembles 1-3 words per instruction
// and queues them in instr_fifo. Define INSTR_FETCH_STATS_EN to add issued/sync counters.
module instr_fetch_buf
    import instr_pkg::*;
#(
    parameter int unsigned              OP_W    = DEF_OP_W,
    parameter int unsigned              REG_W   = DEF_REG_W,
    parameter int unsigned              IMM_W   = DEF_IMM_W,
    parameter logic [(1<<OP_W)-1:0]     IMM_OPS = DEF_IMM_OPS,
    parameter int unsigned              DEPTH   = 4
) (
    input  logic clk,
    input  logic rst,
    instr_fetch_buf_if.slave bus
`ifdef INSTR_FETCH_STATS_EN
    ,
    output logic [15:0] issued_cnt,
    output logic [7:0]  sync_cnt
`endif
);
    localparam int unsigned IN_W  = OP_W + REG_W;
    localparam int unsigned ENT_W = OP_W + 3*REG_W + IMM_W;
    localparam int unsigned LO_W  = IMM_W - REG_W;

    fetch_state_e     r_state;
    logic [OP_W-1:0]  r_op;
    logic [REG_W-1:0] r_src_a;
    logic [REG_W-1:0] r_dest;
    logic [REG_W-1:0] r_imm_hi;

    logic             w_accept;
    logic             w_full;
    logic             w_valid;
    logic             w_pop;
    logic [OP_W-1:0]  w_hi;
    logic [REG_W-1:0] w_lo;
    logic             w_push;
    logic [OP_W-1:0]  w_e_op;
    logic [REG_W-1:0] w_e_a;
    logic [REG_W-1:0] w_e_b;
    logic [REG_W-1:0] w_e_d;
    logic [IMM_W-1:0] w_e_imm;
    logic [ENT_W-1:0] w_head;

    assign w_accept     = bus.in_valid && !w_full;
    assign w_pop        = w_valid && bus.out_ready;
    assign w_hi         = bus.in_data[IN_W-1:REG_W];
    assign w_lo         = bus.in_data[REG_W-1:0];
    assign bus.in_ready = !w_full;
    assign bus.out_valid = w_valid;
    assign {bus.opcode, bus.src_a, bus.src_b, bus.dest, bus.imm} = w_head;

    // The word completing an instruction is combined with the latched fields and pushed directly.
    always_comb begin
        w_push  = 1'b0;
        w_e_op  = '0;
        w_e_a   = '0;
        w_e_b   = '0;
        w_e_d   = '0;
        w_e_imm = '0;
        if (w_accept) begin
            unique case (r_state)
                W1: if (w_hi == OP_W'(OP_NOP)) begin
                    w_push = 1'b1;
                    w_e_a  = w_lo;
                end
                W2: if (!IMM_OPS[r_op]) begin
                    w_push = 1'b1;
                    w_e_op = r_op;
                    w_e_a  = r_src_a;
                    w_e_b  = w_lo;
                    w_e_d  = w_hi;
                end
                W3: begin
                    w_push  = 1'b1;
                    w_e_op  = r_op;
                    w_e_a   = r_src_a;
                    w_e_d   = r_dest;
                    w_e_imm = {r_imm_hi, bus.in_data[LO_W-1:0]};
                end
                default: ;
            endcase
        end
    end

`ifdef INSTR_FETCH_STATS_EN
    logic [15:0] r_issued_cnt;
    logic [7:0]  r_sync_cnt;
    assign issued_cnt = r_issued_cnt;
    assign sync_cnt   = r_sync_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_issued_cnt <= '0;
        else if (w_pop)
            r_issued_cnt <= r_issued_cnt + 16'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= SYNC;
            r_op     <= '0;
            r_src_a  <= '0;
            r_dest   <= '0;
            r_imm_hi <= '0;
`ifdef INSTR_FETCH_STATS_EN
            r_sync_cnt <= '0;
`endif
        end else if (w_accept) begin
            unique case (r_state)
                SYNC: if (bus.in_data == '1) begin
                    r_state <= W1;
`ifdef INSTR_FETCH_STATS_EN
                    if (r_sync_cnt != '1)
                        r_sync_cnt <= r_sync_cnt + 8'd1;
`endif
                end
                W1: begin
                    r_op    <= w_hi;
                    r_src_a <= w_lo;
                    r_state <= (w_hi == OP_W'(OP_NOP)) ? W1 : W2;
                end
                W2: begin
                    r_dest <= w_hi;
                    if (IMM_OPS[r_op]) begin
                        r_imm_hi <= w_lo;
                        r_state  <= W3;
                    end else begin
                        r_state  <= W1;
                    end
                end
                W3: r_state <= W1;
                default: r_state <= SYNC;
            endcase
        end
    end

    instr_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   ({w_e_op, w_e_a, w_e_b, w_e_d, w_e_imm}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_full  (w_full)
    );
endmodule

// File: tb/tb_instr_fetch_buf.sv
// Directed bench for instr_fetch_buf: table of single instructions plus hand-written
// backpressure, pre-sync and mid-instruction reset sequences.
module tb_instr_fetch_buf;
    import instr_pkg::*;

    typedef struct {
        int unsigned nw;
        logic [5:0]  w0;
        logic [5:0]  w1;
        logic [5:0]  w2;
        int unsigned gap;
        instr_t      exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned n_pops  = 0;

    instr_fetch_buf_if #(.OP_W(3), .REG_W(3), .IMM_W(8)) bus ();

`ifdef INSTR_FETCH_STATS_EN
    logic [15:0] issued_cnt;
    logic [7:0]  sync_cnt;
`endif

    instr_fetch_buf #(
        .OP_W    (3),
        .REG_W   (3),
        .IMM_W   (8),
        .IMM_OPS (8'hD4),
        .DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef INSTR_FETCH_STATS_EN
        ,
        .issued_cnt (issued_cnt),
        .sync_cnt   (sync_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic instr_t mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                  input logic [2:0] d, input logic [7:0] imm);
        mk = {op, a, b, d, imm};
    endfunction

    function automatic vec_t mv(input int unsigned nw, input logic [5:0] w0, input logic [5:0] w1,
                                input logic [5:0] w2, input int unsigned gap, input instr_t exp);
        mv.nw  = nw;
        mv.w0  = w0;
        mv.w1  = w1;
        mv.w2  = w2;
        mv.gap = gap;
        mv.exp = exp;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_word(input logic [5:0] w);
        logic acc;
        acc = 1'b0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        bus.in_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic pop_chk(input string nm, input instr_t exp);
        chk({nm, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({nm, "_fields"}, {12'd0, bus.opcode, bus.src_a, bus.src_b, bus.dest, bus.imm}, {12'd0, exp});
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_pops++;
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({nm, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        chk({nm, "_fields"}, {12'd0, bus.opcode, bus.src_a, bus.src_b, bus.dest, bus.imm}, 32'd0);
    endtask

    vec_t       vecs [10];
    logic [5:0] w4a  [5];
    logic [5:0] w4b  [5];
    instr_t     e4   [5];

    initial begin
        vecs[0] = mv(2, 6'o12, 6'o35, 6'o00, 2, mk(3'd1, 3'd2, 3'd5, 3'd3, 8'h00));
        vecs[1] = mv(3, 6'o24, 6'o65, 6'h1A, 0, mk(3'd2, 3'd4, 3'd0, 3'd6, 8'hBA));
        vecs[2] = mv(1, 6'o07, 6'o00, 6'o00, 0, mk(3'd0, 3'd7, 3'd0, 3'd0, 8'h00));
        vecs[3] = mv(1, 6'o07, 6'o00, 6'o00, 0, mk(3'd0, 3'd7, 3'd0, 3'd0, 8'h00));
        vecs[4] = mv(2, 6'o12, 6'o35, 6'o00, 0, mk(3'd1, 3'd2, 3'd5, 3'd3, 8'h00));
        vecs[5] = mv(3, 6'o77, 6'o21, 6'h3F, 1, mk(3'd7, 3'd7, 3'd0, 3'd2, 8'h3F));
        vecs[6] = mv(2, 6'o31, 6'o46, 6'o00, 0, mk(3'd3, 3'd1, 3'd6, 3'd4, 8'h00));
        vecs[7] = mv(3, 6'o43, 6'o70, 6'h05, 3, mk(3'd4, 3'd3, 3'd0, 3'd7, 8'h05));
        vecs[8] = mv(2, 6'o55, 6'o12, 6'o00, 0, mk(3'd5, 3'd5, 3'd2, 3'd1, 8'h00));
        vecs[9] = mv(3, 6'o66, 6'o17, 6'h00, 0, mk(3'd6, 3'd6, 3'd0, 3'd1, 8'hE0));

        w4a = '{6'o12, 6'o31, 6'o55, 6'o13, 6'o36};
        w4b = '{6'o35, 6'o46, 6'o12, 6'o27, 6'o50};
        e4[0] = mk(3'd1, 3'd2, 3'd5, 3'd3, 8'h00);
        e4[1] = mk(3'd3, 3'd1, 3'd6, 3'd4, 8'h00);
        e4[2] = mk(3'd5, 3'd5, 3'd2, 3'd1, 8'h00);
        e4[3] = mk(3'd1, 3'd3, 3'd7, 3'd2, 8'h00);
        e4[4] = mk(3'd3, 3'd6, 3'd0, 3'd5, 8'h00);

        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_state("reset");

        // Words before sync are dropped
        send_word(6'h00);
        send_word(6'h15);
        chk("presync_empty", {31'd0, bus.out_valid}, 32'd0);
        send_word(6'h3F);

        foreach (vecs[k]) begin
            logic [5:0] ws [3];
            ws[0] = vecs[k].w0;
            ws[1] = vecs[k].w1;
            ws[2] = vecs[k].w2;
            for (int unsigned j = 0; j < vecs[k].nw; j++) begin
                if (j == vecs[k].nw - 1)
                    chk($sformatf("vec%0d_notyet", k), {31'd0, bus.out_valid}, 32'd0);
                send_word(ws[j]);
                if (j + 1 < vecs[k].nw)
                    repeat (vecs[k].gap) @(posedge clk);
                #0;
            end
            pop_chk($sformatf("vec%0d", k), vecs[k].exp);
        end
        chk("table_drained", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: four entries fill the FIFO, the fifth instruction's first word waits
        for (int i = 0; i < 4; i++) begin
            send_word(w4a[i]);
            send_word(w4b[i]);
        end
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_data  = w4a[4];
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("held_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("held_head", {12'd0, bus.opcode, bus.src_a, bus.src_b, bus.dest, bus.imm}, {12'd0, e4[0]});
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_pops++;
        chk("after_pop_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        send_word(w4b[4]);
        chk("refull_in_ready", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 1; i < 5; i++)
            pop_chk($sformatf("bp%0d", i), e4[i]);
        chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);

`ifdef INSTR_FETCH_STATS_EN
        chk("stats_sync_pre", {24'd0, sync_cnt}, 32'd1);
        chk("stats_issued_pre", {16'd0, issued_cnt}, n_pops);
`endif

        // Reset with two entries queued and an immediate op half assembled
        send_word(6'o12);
        send_word(6'o35);
        send_word(6'o07);
        send_word(6'o24);
        send_word(6'o65);
        chk("q2_valid", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_pops = 0;
        chk_reset_state("midrst");
        send_word(6'o24);
        chk("resync_drop", {31'd0, bus.out_valid}, 32'd0);
        send_word(6'h3F);
        send_word(6'o12);
        send_word(6'o35);
        pop_chk("resync", mk(3'd1, 3'd2, 3'd5, 3'd3, 8'h00));
        chk("resync_drained", {31'd0, bus.out_valid}, 32'd0);
`ifdef INSTR_FETCH_STATS_EN
        chk("stats_sync", {24'd0, sync_cnt}, 32'd1);
        chk("stats_issued", {16'd0, issued_cnt}, n_pops);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
